// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, flush and a saturating bubble counter.
// Define PIPE_STAGE_SKID_EN to build a 2-entry skid buffer instead of the single-entry stage.
module pipe_stage_reg #(
  parameter int          DATA_W   = 128,
  parameter logic [31:0] NOP_INST = 32'h00000033,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [31:0]       head_inst;
  logic [DATA_W-1:0] head_data;
  logic              push;
  logic              pop;

  assign out_valid = (state != ST_EMPTY);
  assign pop       = out_valid && out_ready && !stall;
  assign push      = in_valid && in_ready;
  assign out_inst  = out_valid ? head_inst : NOP_INST;
  assign out_data  = out_valid ? head_data : '0;

`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] ST_TWO = 2'd2;

  logic [31:0]       tail_inst;
  logic [DATA_W-1:0] tail_data;
  logic              room_q;

  // Room for another entry is registered from the next state; stall and reset still gate it at once.
  assign in_ready = room_q && !stall && rst_n;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (push) state_nxt = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_nxt = ST_TWO;
          else if (pop && !push) state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      room_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      room_q <= (state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            head_inst <= in_inst;
            head_data <= in_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_inst <= in_inst;
            head_data <= in_data;
          end else if (push) begin
            tail_inst <= in_inst;
            tail_data <= in_data;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_inst <= tail_inst;
            head_data <= tail_data;
          end
        end
        default: ;
      endcase
    end
  end
`else
  // A full stage only accepts a new entry when its current one drains the same cycle.
  assign in_ready = (!out_valid || out_ready) && !stall && rst_n;

  always_comb begin
    state_nxt = state;
    if (flush)     state_nxt = ST_EMPTY;
    else if (push) state_nxt = ST_ONE;
    else if (pop)  state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!flush && push) begin
      head_inst <= in_inst;
      head_data <= in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (!out_valid && out_ready && !stall && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized self-checking bench for pipe_stage_reg against a queue-based reference model.
// Directed phases cover reset, streaming, stall, flush collision and counter saturation.
module tb_pipe_stage_reg;

  localparam int          DATA_W   = 64;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] NOP      = 32'h00000033;
`ifdef PIPE_STAGE_SKID_EN
  localparam int          CAPACITY = 2;
`else
  localparam int          CAPACITY = 1;
`endif

  typedef struct {
    logic [31:0]       inst;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  bubble_cnt;

  entry_t model_q[$];
  int     model_cnt;
  int     checks = 0;
  int     errors = 0;

  pipe_stage_reg #(
    .DATA_W  (DATA_W),
    .NOP_INST(NOP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_data   (in_data),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_data  (out_data),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, checks every output against the model, then advances the model at the edge.
  task automatic applyStimulus(input logic iv, input logic [31:0] inst, input logic [DATA_W-1:0] data,
                               input logic st, input logic fl, input logic ordy);
    bit exp_valid;
    bit exp_ready;
    bit do_push;
    bit do_pop;
    entry_t e;
    in_valid  = iv;
    in_inst   = inst;
    in_data   = data;
    stall     = st;
    flush     = fl;
    out_ready = ordy;
    #1;
    exp_valid = (model_q.size() > 0);
    if (CAPACITY == 2) exp_ready = (model_q.size() < 2) && !st;
    else               exp_ready = (!exp_valid || ordy) && !st;
    checkOutput("out_valid", 128'(out_valid), 128'(exp_valid));
    checkOutput("in_ready", 128'(in_ready), 128'(exp_ready));
    checkOutput("out_inst", 128'(out_inst), exp_valid ? 128'(model_q[0].inst) : 128'(NOP));
    checkOutput("out_data", 128'(out_data), exp_valid ? 128'(model_q[0].data) : 128'(0));
    checkOutput("bubble_cnt", 128'(bubble_cnt), 128'(model_cnt));
    do_push = iv && exp_ready;
    do_pop  = exp_valid && ordy && !st;
    @(posedge clk);
    if (!exp_valid && ordy && !st && model_cnt < (1 << CNT_W) - 1) model_cnt++;
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.inst = inst;
        e.data = data;
        model_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic checkReset();
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_out_inst", 128'(out_inst), 128'(NOP));
    checkOutput("rst_out_data", 128'(out_data), 128'(0));
    checkOutput("rst_bubble_cnt", 128'(bubble_cnt), 128'(0));
    checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_data   = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_cnt = 0;
    #2;
    checkReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 32'h00500093 + 32'(i), {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'hA000_0001, 64'h1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB000_0002, 64'h2222, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC000_0003, 64'h3333, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'hDEADBEEF, 64'hBEEF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h1234_0000 + 32'(i), 64'h5555, 1'b1, 1'b0, 1'b1);
    checkOutput("stall_hold", 128'(out_inst), 128'(32'hDEADBEEF));

    applyStimulus(1'b1, 32'hAAAA_0001, 64'hA1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBBBB_0002, 64'hB2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hCCCC_0003, 64'hC3, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_valid", 128'(out_valid), 128'(0));
    checkOutput("flush_inst", 128'(out_inst), 128'(NOP));
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("bubble_sat", 128'(bubble_cnt), 128'(15));

    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom, {$urandom, $urandom},
                    $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);

    applyStimulus(1'b1, 32'h7777_0007, 64'h77, 1'b0, 1'b0, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkReset();
    model_q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 100; i++)
      applyStimulus($urandom_range(0, 1) != 0, $urandom, {$urandom, $urandom},
                    $urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 1) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
